// File: rtl/reg_wb_pkg.sv
// reg_writeback shared types: queue entry layout and source select.
// Optional bypass search is enabled by defining WB_BYPASS_EN.
package reg_wb_pkg;

    localparam int WB_DATA_W = 64;
    localparam int WB_RD_W   = 5;

    typedef struct packed {
        logic [WB_RD_W-1:0]   rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        WB_SRC_LD  = 1'b0,
        WB_SRC_ALU = 1'b1
    } wb_src_e;

    function automatic logic is_live(
        input logic [WB_RD_W-1:0] rd
    );
        return rd != '0;
    endfunction

endpackage

// File: rtl/reg_writeback_fifo.sv
// wb_fifo: dual-push / single-pop circular queue of writeback entries.
// Entry array and head pointer are exported only when WB_BYPASS_EN is set.
module wb_fifo
    import reg_wb_pkg::*;
#(
    parameter int DEPTH_POW = 2
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               push_a,
    input  wb_entry_t          entry_a,
    input  logic               push_b,
    input  wb_entry_t          entry_b,
    input  logic               pop,
    output wb_entry_t          head_entry,
    output logic [DEPTH_POW:0] count
`ifdef WB_BYPASS_EN
    ,
    output logic [DEPTH_POW-1:0]           head_ptr,
    output wb_entry_t [(1<<DEPTH_POW)-1:0] entries
`endif
);

    localparam int DEPTH = 1 << DEPTH_POW;
    localparam int CW    = DEPTH_POW + 1;

    wb_entry_t            mem [DEPTH];
    logic [DEPTH_POW-1:0] head;
    logic [DEPTH_POW-1:0] tail;
    logic [DEPTH_POW-1:0] tail_b;

    // Port B lands behind port A when both push together.
    assign tail_b = push_a ? tail + DEPTH_POW'(1) : tail;

    always_ff @(posedge clk_in) begin
        if (push_a) mem[tail]   <= entry_a;
        if (push_b) mem[tail_b] <= entry_b;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + DEPTH_POW'(pop);
            tail  <= tail + DEPTH_POW'(push_a)
                          + DEPTH_POW'(push_b);
            count <= count + CW'(push_a)
                           + CW'(push_b)
                           - CW'(pop);
        end
    end

    assign head_entry = mem[head];

`ifdef WB_BYPASS_EN
    assign head_ptr = head;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries[i] = mem[i];
        end
    end
`endif

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: arbitrates ALU/load results into an in-order queue.
// Drains one register write per cycle; WB_BYPASS_EN adds rs1/rs2 lookup.
module reg_writeback
    import reg_wb_pkg::*;
#(
    parameter int REG_DATA_WIDTH_POW = 6,
    parameter int REG_MEM_DEPTH_POW  = 5,
    parameter int WB_FIFO_DEPTH_POW  = 2
) (
    input  logic                               clk_in,
    input  logic                               rst_n_in,
    input  logic                               alu_valid_in,
    input  logic [REG_MEM_DEPTH_POW-1:0]       alu_rd_in,
    input  logic [(1<<REG_DATA_WIDTH_POW)-1:0] alu_data_in,
    output logic                               alu_ready_out,
    input  logic                               ld_valid_in,
    input  logic [REG_MEM_DEPTH_POW-1:0]       ld_rd_in,
    input  logic [(1<<REG_DATA_WIDTH_POW)-1:0] ld_data_in,
    output logic                               ld_ready_out,
    output logic [REG_MEM_DEPTH_POW-1:0]       rd_out,
    output logic [(1<<REG_DATA_WIDTH_POW)-1:0] data_write_out,
    output logic                               write_en_out,
    output logic [WB_FIFO_DEPTH_POW:0]         pending_count_out
`ifdef WB_BYPASS_EN
    ,
    input  logic [REG_MEM_DEPTH_POW-1:0]       rs1_in,
    input  logic [REG_MEM_DEPTH_POW-1:0]       rs2_in,
    output logic                               fwd1_hit_out,
    output logic                               fwd2_hit_out,
    output logic [(1<<REG_DATA_WIDTH_POW)-1:0] fwd1_data_out,
    output logic [(1<<REG_DATA_WIDTH_POW)-1:0] fwd2_data_out
`endif
);

    localparam int DEPTH = 1 << WB_FIFO_DEPTH_POW;
    localparam int CW    = WB_FIFO_DEPTH_POW + 1;

    wb_src_e       rr_ptr;
    logic [CW-1:0] count;
    wb_entry_t     head_entry;
    wb_entry_t     ld_entry;
    wb_entry_t     alu_entry;
    logic          free2;
    logic          free1;
    logic          contend;
    logic          ld_push;
    logic          alu_push;

    assign free2   = count <= CW'(DEPTH - 2);
    assign free1   = count == CW'(DEPTH - 1);
    assign contend = free1 && ld_valid_in && alu_valid_in;

    assign ld_ready_out = rst_n_in && (free2 || (free1 &&
        (!alu_valid_in || rr_ptr == WB_SRC_LD)));
    assign alu_ready_out = rst_n_in && (free2 || (free1 &&
        (!ld_valid_in || rr_ptr == WB_SRC_ALU)));

    // x0 results complete the handshake but never occupy a slot.
    assign ld_push  = ld_valid_in && ld_ready_out
                   && is_live(ld_rd_in);
    assign alu_push = alu_valid_in && alu_ready_out
                   && is_live(alu_rd_in);

    assign ld_entry  = '{rd: ld_rd_in, data: ld_data_in};
    assign alu_entry = '{rd: alu_rd_in, data: alu_data_in};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rr_ptr <= WB_SRC_LD;
        end else if (contend) begin
            rr_ptr <= (rr_ptr == WB_SRC_LD) ? WB_SRC_ALU
                                            : WB_SRC_LD;
        end
    end

`ifdef WB_BYPASS_EN
    logic [WB_FIFO_DEPTH_POW-1:0] head_ptr;
    wb_entry_t [DEPTH-1:0]        entries;
`endif

    wb_fifo #(
        .DEPTH_POW (WB_FIFO_DEPTH_POW)
    ) u_fifo (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .push_a     (ld_push),
        .entry_a    (ld_entry),
        .push_b     (alu_push),
        .entry_b    (alu_entry),
        .pop        (write_en_out),
        .head_entry (head_entry),
        .count      (count)
`ifdef WB_BYPASS_EN
        ,
        .head_ptr   (head_ptr),
        .entries    (entries)
`endif
    );

    assign write_en_out      = count != '0;
    assign rd_out            = write_en_out ? head_entry.rd : '0;
    assign data_write_out    = write_en_out ? head_entry.data : '0;
    assign pending_count_out = count;

`ifdef WB_BYPASS_EN
    // Walk oldest to youngest so the last match is the freshest value.
    function automatic logic [WB_DATA_W:0] lookup(
        input logic [WB_RD_W-1:0] rs
    );
        logic [WB_DATA_W:0]           r;
        logic [WB_FIFO_DEPTH_POW-1:0] idx;
        r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_ptr + WB_FIFO_DEPTH_POW'(i);
            if (CW'(i) < count && rs != '0
                && entries[idx].rd == rs) begin
                r = {1'b1, entries[idx].data};
            end
        end
        return r;
    endfunction

    assign {fwd1_hit_out, fwd1_data_out} = lookup(rs1_in);
    assign {fwd2_hit_out, fwd2_data_out} = lookup(rs2_in);
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback against a queue-based model.
// Bypass scenarios are compiled in when WB_BYPASS_EN is defined.
module tb_reg_writeback;
    import reg_wb_pkg::*;

    localparam int DEPTH = 4;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        ldv, aluv;
    logic [4:0]  ldrd, alurd;
    logic [63:0] ldd, alud;
    logic        ld_ready_out, alu_ready_out;
    logic [4:0]  rd_out;
    logic [63:0] data_write_out;
    logic        write_en_out;
    logic [2:0]  pending_count_out;
`ifdef WB_BYPASS_EN
    logic [4:0]  rs1, rs2;
    logic        fwd1_hit_out, fwd2_hit_out;
    logic [63:0] fwd1_data_out, fwd2_data_out;
`endif

    int checks = 0;
    int failures = 0;

    wb_entry_t q[$];
    bit        m_rr;
    bit        m_acc_l, m_acc_a;

    always #5 clk_in = ~clk_in;

    reg_writeback dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .alu_valid_in      (aluv),
        .alu_rd_in         (alurd),
        .alu_data_in       (alud),
        .alu_ready_out     (alu_ready_out),
        .ld_valid_in       (ldv),
        .ld_rd_in          (ldrd),
        .ld_data_in        (ldd),
        .ld_ready_out      (ld_ready_out),
        .rd_out            (rd_out),
        .data_write_out    (data_write_out),
        .write_en_out      (write_en_out),
        .pending_count_out (pending_count_out)
`ifdef WB_BYPASS_EN
        ,
        .rs1_in            (rs1),
        .rs2_in            (rs2),
        .fwd1_hit_out      (fwd1_hit_out),
        .fwd2_hit_out      (fwd2_hit_out),
        .fwd1_data_out     (fwd1_data_out),
        .fwd2_data_out     (fwd2_data_out)
`endif
    );

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Expected readies from the free-slot rule and round-robin owner.
    function automatic void mdl_ready(output bit lr, output bit ar);
        int free;
        free = DEPTH - q.size();
        if (free >= 2) begin
            lr = 1; ar = 1;
        end else if (free == 1) begin
            lr = !(aluv && m_rr);
            ar = !(ldv && !m_rr);
        end else begin
            lr = 0; ar = 0;
        end
    endfunction

`ifdef WB_BYPASS_EN
    function automatic logic [64:0] mdl_fwd(input logic [4:0] rs);
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (rs != 0 && q[i].rd == rs) return {1'b1, q[i].data};
        end
        return '0;
    endfunction
`endif

    // Advance the model through the coming edge, then step the clock.
    task automatic tick();
        bit lr, ar;
        mdl_ready(lr, ar);
        m_acc_l = ldv && lr;
        m_acc_a = aluv && ar;
        if (DEPTH - q.size() == 1 && ldv && aluv) m_rr = !m_rr;
        if (q.size() > 0) void'(q.pop_front());
        if (m_acc_l && ldrd != 0) q.push_back('{rd: ldrd, data: ldd});
        if (m_acc_a && alurd != 0) q.push_back('{rd: alurd, data: alud});
        @(posedge clk_in);
        #1;
    endtask

    task automatic drain();
        for (int c = 0; c < 32; c++) begin
            if (!ldv && !aluv && q.size() == 0) break;
            tick();
            if (m_acc_l) ldv = 0;
            if (m_acc_a) aluv = 0;
        end
    endtask

    task automatic test_reset();
        rst_n_in = 0;
        ldv = 1; ldrd = 1; ldd = 64'h1;
        aluv = 1; alurd = 2; alud = 64'h2;
`ifdef WB_BYPASS_EN
        rs1 = 1; rs2 = 2;
`endif
        #12;
        checks++;
        if (ld_ready_out !== 0 || alu_ready_out !== 0) begin
            failures++;
            $display("FAIL reset_ready: ld=%b alu=%b want 0 0",
                     ld_ready_out, alu_ready_out);
        end
        checks++;
        if (write_en_out !== 0 || rd_out !== 0 || data_write_out !== 0) begin
            failures++;
            $display("FAIL reset_write: we=%b rd=%0d data=%h want zeros",
                     write_en_out, rd_out, data_write_out);
        end
        checks++;
        if (pending_count_out !== 0) begin
            failures++;
            $display("FAIL reset_count: got %0d want 0", pending_count_out);
        end
`ifdef WB_BYPASS_EN
        checks++;
        if (fwd1_hit_out !== 0 || fwd2_hit_out !== 0) begin
            failures++;
            $display("FAIL reset_fwd: hit1=%b hit2=%b want 0 0",
                     fwd1_hit_out, fwd2_hit_out);
        end
        rs1 = 0; rs2 = 0;
`endif
        ldv = 0; aluv = 0;
        q.delete();
        m_rr = 0;
        @(negedge clk_in);
        rst_n_in = 1;
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_single();
        aluv = 1; alurd = 5; alud = 64'hDEAD_BEEF;
        @(negedge clk_in);
        checks++;
        if (alu_ready_out !== 1 || write_en_out !== 0) begin
            failures++;
            $display("FAIL single_accept: ready=%b we=%b want 1 0",
                     alu_ready_out, write_en_out);
        end
        tick();
        aluv = 0;
        @(negedge clk_in);
        checks++;
        if (write_en_out !== 1 || rd_out !== 5
            || data_write_out !== 64'hDEAD_BEEF) begin
            failures++;
            $display("FAIL single_write: we=%b rd=%0d data=%h want 1 5 deadbeef",
                     write_en_out, rd_out, data_write_out);
        end
        checks++;
        if (pending_count_out !== 1) begin
            failures++;
            $display("FAIL single_count1: got %0d want 1", pending_count_out);
        end
        tick();
        @(negedge clk_in);
        checks++;
        if (pending_count_out !== 0 || write_en_out !== 0) begin
            failures++;
            $display("FAIL single_drained: count=%0d we=%b want 0 0",
                     pending_count_out, write_en_out);
        end
        tick();
    endtask

    task automatic test_x0();
        aluv = 1; alurd = 0; alud = rnd64();
        @(negedge clk_in);
        checks++;
        if (alu_ready_out !== 1) begin
            failures++;
            $display("FAIL x0_ready: got %b want 1", alu_ready_out);
        end
        tick();
        aluv = 0;
        @(negedge clk_in);
        checks++;
        if (write_en_out !== 0 || pending_count_out !== 0) begin
            failures++;
            $display("FAIL x0_absorbed: we=%b count=%0d want 0 0",
                     write_en_out, pending_count_out);
        end
        tick();
    endtask

    task automatic test_same_rd();
        ldv = 1; ldrd = 7; ldd = 64'h11;
        aluv = 1; alurd = 7; alud = 64'h22;
        @(negedge clk_in);
        checks++;
        if (ld_ready_out !== 1 || alu_ready_out !== 1) begin
            failures++;
            $display("FAIL same_rd_ready: ld=%b alu=%b want 1 1",
                     ld_ready_out, alu_ready_out);
        end
        tick();
        ldv = 0; aluv = 0;
        @(negedge clk_in);
        checks++;
        if (write_en_out !== 1 || rd_out !== 7 || data_write_out !== 64'h11) begin
            failures++;
            $display("FAIL same_rd_first: we=%b rd=%0d data=%h want 1 7 11",
                     write_en_out, rd_out, data_write_out);
        end
        tick();
        @(negedge clk_in);
        checks++;
        if (write_en_out !== 1 || rd_out !== 7 || data_write_out !== 64'h22) begin
            failures++;
            $display("FAIL same_rd_second: we=%b rd=%0d data=%h want 1 7 22",
                     write_en_out, rd_out, data_write_out);
        end
        tick();
        @(negedge clk_in);
        checks++;
        if (write_en_out !== 0) begin
            failures++;
            $display("FAIL same_rd_done: we=%b want 0", write_en_out);
        end
        tick();
    endtask

    task automatic test_fill();
        int nw, nacc;
        nw = 0; nacc = 0;
        ldv = 1; ldrd = 1; ldd = rnd64();
        aluv = 1; alurd = 2; alud = rnd64();
        for (int c = 0; c < 24 && (ldv || aluv || q.size() > 0); c++) begin
            @(negedge clk_in);
            if (write_en_out === 1) nw++;
            checks++;
            if (write_en_out !== (q.size() > 0)
                || rd_out !== ((q.size() > 0) ? q[0].rd : 5'd0)
                || data_write_out !== ((q.size() > 0) ? q[0].data : 64'd0)) begin
                failures++;
                $display("FAIL fill_write c=%0d: we=%b rd=%0d data=%h want qsize=%0d",
                         c, write_en_out, rd_out, data_write_out, q.size());
            end
            checks++;
            if (pending_count_out !== 3'(q.size())) begin
                failures++;
                $display("FAIL fill_count c=%0d: got %0d want %0d",
                         c, pending_count_out, q.size());
            end
            tick();
            if (m_acc_l) nacc++;
            if (m_acc_a) nacc++;
            if (m_acc_l) begin
                if (c < 3) ldd = rnd64(); else ldv = 0;
            end
            if (m_acc_a) begin
                if (c < 3) alud = rnd64(); else aluv = 0;
            end
        end
        checks++;
        if (ldv || aluv || q.size() != 0 || write_en_out !== 0) begin
            failures++;
            $display("FAIL fill_timeout: queue not drained, we=%b qsize=%0d",
                     write_en_out, q.size());
        end
        checks++;
        if (nw != nacc) begin
            failures++;
            $display("FAIL fill_conserve: writes=%0d want %0d", nw, nacc);
        end
    endtask

    task automatic test_arbitration();
        rst_n_in = 0;
        #1;
        q.delete();
        m_rr = 0;
        rst_n_in = 1;
        ldv = 1; ldrd = 3; ldd = rnd64();
        aluv = 1; alurd = 4; alud = rnd64();
        tick();
        ldd = rnd64(); alud = rnd64();
        tick();
        ldd = rnd64(); alud = rnd64();
        @(negedge clk_in);
        checks++;
        if (pending_count_out !== 3) begin
            failures++;
            $display("FAIL arb_count: got %0d want 3", pending_count_out);
        end
        checks++;
        if (ld_ready_out !== 1 || alu_ready_out !== 0) begin
            failures++;
            $display("FAIL arb_first: ld=%b alu=%b want 1 0",
                     ld_ready_out, alu_ready_out);
        end
        tick();
        if (m_acc_l) ldd = rnd64();
        @(negedge clk_in);
        checks++;
        if (ld_ready_out !== 0 || alu_ready_out !== 1) begin
            failures++;
            $display("FAIL arb_second: ld=%b alu=%b want 0 1",
                     ld_ready_out, alu_ready_out);
        end
        tick();
        if (m_acc_a) aluv = 0;
        if (m_acc_l) ldv = 0;
        drain();
        checks++;
        if (pending_count_out !== 0 || ldv || aluv) begin
            failures++;
            $display("FAIL arb_drain: count=%0d want 0", pending_count_out);
        end
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass();
        ldv = 1; ldrd = 9; ldd = 64'hA;
        aluv = 1; alurd = 9; alud = 64'hB;
        tick();
        ldv = 0; aluv = 0;
        rs1 = 9; rs2 = 0;
        @(negedge clk_in);
        checks++;
        if (fwd1_hit_out !== 1 || fwd1_data_out !== 64'hB) begin
            failures++;
            $display("FAIL byp_young: hit=%b data=%h want 1 b",
                     fwd1_hit_out, fwd1_data_out);
        end
        checks++;
        if (fwd2_hit_out !== 0) begin
            failures++;
            $display("FAIL byp_x0: hit=%b want 0", fwd2_hit_out);
        end
        rs2 = 5;
        #1;
        checks++;
        if (fwd2_hit_out !== 0) begin
            failures++;
            $display("FAIL byp_miss: hit=%b want 0", fwd2_hit_out);
        end
        rs1 = 0; rs2 = 0;
        drain();
    endtask
`endif

    task automatic test_reset_mid_drain();
        ldv = 1; ldrd = 12; ldd = rnd64();
        aluv = 1; alurd = 13; alud = rnd64();
        tick();
        ldd = rnd64(); alud = rnd64();
        tick();
        ldv = 0; aluv = 0;
        checks++;
        if (write_en_out !== 1 || pending_count_out !== 3) begin
            failures++;
            $display("FAIL mid_pre: we=%b count=%0d want 1 3",
                     write_en_out, pending_count_out);
        end
        rst_n_in = 0;
        #1;
        checks++;
        if (write_en_out !== 0 || pending_count_out !== 0
            || ld_ready_out !== 0 || alu_ready_out !== 0) begin
            failures++;
            $display("FAIL mid_reset: we=%b count=%0d rdy=%b%b want 0 0 00",
                     write_en_out, pending_count_out,
                     ld_ready_out, alu_ready_out);
        end
        q.delete();
        m_rr = 0;
        @(negedge clk_in);
        rst_n_in = 1;
        @(posedge clk_in);
        #1;
        checks++;
        if (write_en_out !== 0 || pending_count_out !== 0
            || ld_ready_out !== 1) begin
            failures++;
            $display("FAIL mid_release: we=%b count=%0d rdy=%b want 0 0 1",
                     write_en_out, pending_count_out, ld_ready_out);
        end
    endtask

    task automatic test_random();
        bit lr, ar;
        int free;
        ldv = 0; aluv = 0;
        for (int c = 0; c < 400; c++) begin
            if (!ldv || m_acc_l) begin
                ldv = ($urandom % 4) != 0;
                ldrd = 5'($urandom_range(0, 7));
                ldd = rnd64();
            end
            if (!aluv || m_acc_a) begin
                aluv = ($urandom % 4) != 0;
                alurd = 5'($urandom_range(0, 7));
                alud = rnd64();
            end
`ifdef WB_BYPASS_EN
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
`endif
            @(negedge clk_in);
            mdl_ready(lr, ar);
            free = DEPTH - q.size();
            if (free != 1 || ldv) begin
                checks++;
                if (ld_ready_out !== lr) begin
                    failures++;
                    $display("FAIL rnd_ld_ready c=%0d: got %b want %b",
                             c, ld_ready_out, lr);
                end
            end
            if (free != 1 || aluv) begin
                checks++;
                if (alu_ready_out !== ar) begin
                    failures++;
                    $display("FAIL rnd_alu_ready c=%0d: got %b want %b",
                             c, alu_ready_out, ar);
                end
            end
            checks++;
            if (write_en_out !== (q.size() > 0)
                || rd_out !== ((q.size() > 0) ? q[0].rd : 5'd0)
                || data_write_out !== ((q.size() > 0) ? q[0].data : 64'd0)) begin
                failures++;
                $display("FAIL rnd_write c=%0d: we=%b rd=%0d data=%h qsize=%0d",
                         c, write_en_out, rd_out, data_write_out, q.size());
            end
            checks++;
            if (pending_count_out !== 3'(q.size())) begin
                failures++;
                $display("FAIL rnd_count c=%0d: got %0d want %0d",
                         c, pending_count_out, q.size());
            end
`ifdef WB_BYPASS_EN
            checks++;
            if ({fwd1_hit_out, fwd1_data_out} !== mdl_fwd(rs1)
                || {fwd2_hit_out, fwd2_data_out} !== mdl_fwd(rs2)) begin
                failures++;
                $display("FAIL rnd_fwd c=%0d: got %b/%h %b/%h",
                         c, fwd1_hit_out, fwd1_data_out,
                         fwd2_hit_out, fwd2_data_out);
            end
`endif
            tick();
        end
        if (m_acc_l) ldv = 0;
        if (m_acc_a) aluv = 0;
`ifdef WB_BYPASS_EN
        rs1 = 0; rs2 = 0;
`endif
        drain();
        checks++;
        if (pending_count_out !== 0 || ldv || aluv) begin
            failures++;
            $display("FAIL rnd_drain: count=%0d want 0", pending_count_out);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_x0();
        test_same_rd();
        test_fill();
        test_arbitration();
`ifdef WB_BYPASS_EN
        test_bypass();
`endif
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Writeback collector sitting directly upstream of the register file. Accepts completed results from the ALU and load paths over independent valid/ready handshakes, buffers them in a small in-order queue, and drains exactly one write per cycle onto the register file write port (`rd_in`, `data_write`, `write_en`). Writes to x0 are absorbed without using a slot. An optional bypass port lets decode read results still pending in the queue.

## Interface
- `REG_DATA_WIDTH_POW`, 6, log2 of data width (REG_DATA_WIDTH = 64)
- `REG_MEM_DEPTH_POW`, 5, log2 of register count (rd width 5)
- `WB_FIFO_DEPTH_POW`, 2, log2 of queue depth (4 entries); minimum 1
- `clk_in` in 1: sole clock, rising edge
- `rst_n_in` in 1: reset, asynchronous assert, active-low
- `alu_valid_in` in 1: ALU result valid
- `alu_rd_in` in REG_MEM_DEPTH_POW: ALU destination register
- `alu_data_in` in REG_DATA_WIDTH: ALU result
- `alu_ready_out` out 1: ALU result accepted this cycle if valid
- `ld_valid_in`, `ld_rd_in`, `ld_data_in`, `ld_ready_out`: same, load path
- `rd_out` out REG_MEM_DEPTH_POW: to register file `rd_in`
- `data_write_out` out REG_DATA_WIDTH: to register file `data_write`
- `write_en_out` out 1: to register file `write_en`
- `pending_count_out` out WB_FIFO_DEPTH_POW+1: queued entries
- `rs1_in`, `rs2_in` in REG_MEM_DEPTH_POW: bypass lookup indices (WB_BYPASS_EN only)
- `fwd1_hit_out`, `fwd2_hit_out` out 1; `fwd1_data_out`, `fwd2_data_out` out REG_DATA_WIDTH (WB_BYPASS_EN only)

## Operation
- Queue: circular buffer, head/tail pointers, count 0..DEPTH. Entry = {rd, data}.
- Drain: when count > 0, head entry drives `rd_out`/`data_write_out`, `write_en_out`=1, popped at the rising edge. The register file is never back-pressured. When empty: `write_en_out`=0; `rd_out` and `data_write_out` are 0.
- Space rule, with free = DEPTH − count (count from the registered state, before this cycle's pop):
  - free ≥ 2: both readies high.
  - free = 1: a lone valid source is ready. If both are valid, only the source selected by `rr_ptr` is ready.
  - free = 0: both readies low.
- `rr_ptr` is a 1-bit register, reset to LD. It toggles to the other source after any cycle in which the free = 1 arbitration granted one source over a valid competitor.
- Handshake: a transfer occurs when valid && ready at the edge. Valid must hold, with rd and data stable, until the transfer.
- x0: a transfer with rd = 0 completes the handshake but enqueues nothing. It still obeys the space rule.
- Simultaneous transfers are enqueued load first, then ALU. If both target the same rd, the ALU value is written last.
- Count update per edge: count + enqueued (0..2) − popped (0/1).
- Reset: all pointers, count, and `rr_ptr` are cleared; queued writes are discarded. All outputs read 0, including readies, for as long as `rst_n_in` is low.

## Timing
- Latency: a result accepted at edge N into an empty queue drives `write_en_out` during cycle N+1 and is written into the register file at edge N+1.
- Throughput: one register write per cycle sustained. Two accepts per cycle are absorbed up to the queue depth.
- Readies are combinational from registered count/`rr_ptr` and the opposite source's valid only. There is no path from the ready outputs back into their own valid/data inputs.
- Bypass outputs are purely combinational from queue contents and `rs*_in`.

## Configuration
- `WB_BYPASS_EN` defined:
  - Bypass ports exist.
  - `fwdN_hit_out`=1 when `rsN_in` ≠ 0 and it matches any queued entry's rd; `fwdN_data_out` is the data of the youngest matching entry.
  - Same-cycle incoming transfers are not searched.
- `WB_BYPASS_EN` undefined: the bypass ports and match logic are absent.

## Structure
- Package `reg_wb_pkg`: `wb_entry_t` packed struct {rd, data}; `wb_src_e` enum {WB_SRC_LD, WB_SRC_ALU}.
- Sub-module `wb_fifo`: a parameterised dual-push/single-pop queue with entry array exposure for bypass.
- The top level holds arbitration, x0 filtering, and the bypass search.

## Test plan
- Reset, then single ALU write rd=5, data=0xDEAD_BEEF at edge 1 → `write_en_out`=1, `rd_out`=5 in cycle 2; count returns to 0 at edge 2.
- Both sources valid each cycle, rd=1 (ld) and rd=2 (alu), for 4 cycles → queue fills. Writes emerge in the order 1,2,1,2,… at one per cycle, and no entry is lost or duplicated.
- Queue at count=3 (free=1), both valid → only `ld_ready_out`=1. The next identical cycle grants ALU (rr toggles).
- ALU transfer with rd=0 while the queue is empty → handshake completes; `write_en_out` stays 0; count stays 0.
- Same-cycle ld rd=7 data=0x11 and alu rd=7 data=0x22 → two consecutive writes to 7, 0x11 then 0x22.
- `WB_BYPASS_EN`: queue holds rd=9 data=0xA then rd=9 data=0xB, `rs1_in`=9 → hit, data 0xB. `rs2_in`=0 → no hit. Asserting `rst_n_in`=0 mid-drain → `write_en_out` drops to 0 immediately and the queue is empty after release.
